actmem_decomp_sequencer: RTL and testbench

Sequences one output layer through ITERATIVE_DECOMP passes of the activation-memory writeback path. For each pass it issues a one-cycle latch_new_layer strobe with bank offset and bank stride, then counts writeback valid strobes until the pass's pixel count is reached. It sits between the layer-level control FSM and the actmem write controller, and replaces hand-driven per-pass configuration.

---
 rtl/actmem_decomp_sequencer_if.sv | 49 ++++
 rtl/actmem_decomp_sequencer.sv | 144 ++++++++++++++
 tb/tb_actmem_decomp_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/actmem_decomp_sequencer_if.sv
// Config/handshake bundle between layer control, the decomposition sequencer and the actmem write controller.
// When ACTMEM_SEQ_PERFCNT_EN is defined the bundle also carries cycles_o and stall_cycles_o.
interface actmem_decomp_sequencer_if #(
   parameter int N_O              = 128,
   parameter int IMAGEWIDTH       = 224,
   parameter int IMAGEHEIGHT      = 224,
   parameter int ITERATIVE_DECOMP = 1,
   parameter int PIXW             = $clog2(IMAGEWIDTH*IMAGEHEIGHT)+1,
   parameter int DECW             = $clog2(ITERATIVE_DECOMP)+1
);
   localparam int LNW = $clog2(N_O)+1;

   logic            start_i;
   logic            abort_i;
   logic [LNW-1:0]  layer_no_i;
   logic [DECW-1:0] num_passes_i;
   logic [PIXW-1:0] pixels_i;
   logic            valid_i;
   logic            latch_new_layer_o;
   logic [DECW-1:0] layer_offset_o;
   logic [DECW-1:0] layer_stride_o;
   logic [LNW-1:0]  layer_no_o;
   logic [DECW-1:0] pass_o;
   logic            busy_o;
   logic            done_o;
   logic            error_o;
`ifdef ACTMEM_SEQ_PERFCNT_EN
   logic [31:0]     cycles_o;
   logic [31:0]     stall_cycles_o;
`endif

   modport master (
`ifdef ACTMEM_SEQ_PERFCNT_EN
      input  cycles_o, stall_cycles_o,
`endif
      output start_i, abort_i, layer_no_i, num_passes_i, pixels_i, valid_i,
      input  latch_new_layer_o, layer_offset_o, layer_stride_o, layer_no_o,
      input  pass_o, busy_o, done_o, error_o
   );

   modport slave (
`ifdef ACTMEM_SEQ_PERFCNT_EN
      output cycles_o, stall_cycles_o,
`endif
      input  start_i, abort_i, layer_no_i, num_passes_i, pixels_i, valid_i,
      output latch_new_layer_o, layer_offset_o, layer_stride_o, layer_no_o,
      output pass_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/actmem_decomp_sequencer.sv
// Runs one output layer through num_passes decomposition passes, strobing the actmem write controller per pass.
// Optional perf counters (cycles_o, stall_cycles_o) are built only when ACTMEM_SEQ_PERFCNT_EN is defined.
module actmem_decomp_sequencer #(
   parameter int N_O              = 128,
   parameter int IMAGEWIDTH       = 224,
   parameter int IMAGEHEIGHT      = 224,
   parameter int ITERATIVE_DECOMP = 1,
   parameter int PIXW             = $clog2(IMAGEWIDTH*IMAGEHEIGHT)+1,
   parameter int DECW             = $clog2(ITERATIVE_DECOMP)+1
) (
   input logic                          clk_i,
   input logic                          rst_i,
   actmem_decomp_sequencer_if.slave     bus
);
   localparam int LNW = $clog2(N_O)+1;
   localparam logic [DECW-1:0] MAX_PASSES = DECW'(ITERATIVE_DECOMP);

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_RUN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [DECW-1:0] pass_q, pass_d;
   logic [PIXW-1:0] pix_q, pix_d;
   logic [DECW-1:0] passes_q;
   logic [PIXW-1:0] pixels_q;
   logic [LNW-1:0]  layer_no_q;
   logic [DECW-1:0] off_hold_q, stride_hold_q;
   logic [LNW-1:0]  layer_no_hold_q;
   logic            err_q, err_d;
   logic            load_cfg;
   logic            cfg_legal;
   logic            pass_end;
   logic            is_latch;

   assign cfg_legal = (bus.num_passes_i != '0) && (bus.num_passes_i <= MAX_PASSES)
                   && (bus.pixels_i != '0);
   assign pass_end  = bus.valid_i && (pix_q == pixels_q - PIXW'(1));
   assign is_latch  = (state_q == S_LATCH);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      pix_d    = pix_q;
      load_cfg = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               if (cfg_legal) begin
                  load_cfg = 1'b1;
                  pass_d   = '0;
                  state_d  = S_LATCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LATCH: begin
            pix_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.valid_i) pix_d = pix_q + PIXW'(1);
            if (pass_end) begin
               if ((pass_q + DECW'(1)) < passes_q) begin
                  pass_d  = pass_q + DECW'(1);
                  state_d = S_LATCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // abort overrides everything, including a coincident start
      if (bus.abort_i) begin
         state_d  = S_IDLE;
         pass_d   = '0;
         pix_d    = '0;
         load_cfg = 1'b0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pass_q          <= '0;
         pix_q           <= '0;
         err_q           <= 1'b0;
         off_hold_q      <= '0;
         stride_hold_q   <= '0;
         layer_no_hold_q <= '0;
      end else begin
         pass_q <= pass_d;
         pix_q  <= pix_d;
         err_q  <= err_d;
         if (is_latch) begin
            off_hold_q      <= pass_q;
            stride_hold_q   <= passes_q;
            layer_no_hold_q <= layer_no_q;
         end
      end
   end

   // layer configuration is pure data: captured on an accepted start, never reset
   always_ff @(posedge clk_i) begin
      if (load_cfg) begin
         layer_no_q <= bus.layer_no_i;
         passes_q   <= bus.num_passes_i;
         pixels_q   <= bus.pixels_i;
      end
   end

   assign bus.latch_new_layer_o = is_latch;
   assign bus.layer_offset_o    = is_latch ? pass_q     : off_hold_q;
   assign bus.layer_stride_o    = is_latch ? passes_q   : stride_hold_q;
   assign bus.layer_no_o        = is_latch ? layer_no_q : layer_no_hold_q;
   assign bus.pass_o            = pass_q;
   assign bus.busy_o            = (state_q != S_IDLE);
   assign bus.done_o            = (state_q == S_DONE);
   assign bus.error_o           = err_q;

`ifdef ACTMEM_SEQ_PERFCNT_EN
   logic [31:0] cycles_q, stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || load_cfg) begin
         cycles_q <= '0;
         stall_q  <= '0;
      end else begin
         if ((state_q != S_IDLE) && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;
         if ((state_q == S_RUN) && !bus.valid_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.cycles_o       = cycles_q;
   assign bus.stall_cycles_o = stall_q;
`endif
endmodule

// File: tb/tb_actmem_decomp_sequencer.sv
// Randomized and directed bench for actmem_decomp_sequencer against a pass/pixel-level reference model.
module tb_actmem_decomp_sequencer;
  localparam int N_O  = 128;
  localparam int IW   = 224;
  localparam int IH   = 224;
  localparam int ITD  = 3;
  localparam int PIXW = $clog2(IW*IH)+1;
  localparam int DECW = $clog2(ITD)+1;
  localparam int LNW  = $clog2(N_O)+1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  actmem_decomp_sequencer_if #(.N_O(N_O), .IMAGEWIDTH(IW), .IMAGEHEIGHT(IH),
    .ITERATIVE_DECOMP(ITD), .PIXW(PIXW), .DECW(DECW)) bus ();

  actmem_decomp_sequencer #(.N_O(N_O), .IMAGEWIDTH(IW), .IMAGEHEIGHT(IH),
    .ITERATIVE_DECOMP(ITD), .PIXW(PIXW), .DECW(DECW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: layer in progress, strobes due this cycle, pixels left in the pass
  bit          m_busy, m_latch, m_done, m_err;
  int          m_pass, m_passes, m_pixels, m_left;
  int          m_hoff, m_hstr, m_hln;
  int unsigned m_cyc, m_stall;

  int lat_offs[$];
  int lat_cyc, done_cyc, done_cnt, err_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_step(input bit r, input bit st, input bit ab, input bit vl,
                            input int np, input int px, input int ln);
    bit n_latch, n_done, n_err, running;
    n_latch = 1'b0; n_done = 1'b0; n_err = 1'b0;
    running = m_busy && !m_latch && !m_done;
    if (r) begin
      m_busy = 1'b0; m_pass = 0; m_hoff = 0; m_hstr = 0; m_hln = 0;
      m_cyc = 0; m_stall = 0;
    end else begin
      if (m_busy && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (running && !vl && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (ab) begin
        m_busy = 1'b0; m_pass = 0;
      end else if (!m_busy) begin
        if (st) begin
          if (np >= 1 && np <= ITD && px != 0) begin
            m_busy = 1'b1; n_latch = 1'b1; m_pass = 0; m_passes = np; m_pixels = px;
            m_hoff = 0; m_hstr = np; m_hln = ln; m_cyc = 0; m_stall = 0;
          end else begin
            n_err = 1'b1;
          end
        end
      end else if (m_latch) begin
        m_left = m_pixels;
      end else if (m_done) begin
        m_busy = 1'b0;
      end else if (vl) begin
        m_left--;
        if (m_left == 0) begin
          if (m_pass + 1 < m_passes) begin
            m_pass++; n_latch = 1'b1; m_hoff = m_pass;
          end else begin
            n_done = 1'b1;
          end
        end
      end
    end
    m_latch = n_latch; m_done = n_done; m_err = n_err;
  endtask

  task automatic compare_all();
    chk("latch",    32'(bus.latch_new_layer_o), 32'(m_latch));
    chk("busy",     32'(bus.busy_o),            32'(m_busy));
    chk("done",     32'(bus.done_o),            32'(m_done));
    chk("error",    32'(bus.error_o),           32'(m_err));
    chk("pass",     32'(bus.pass_o),            32'(m_pass));
    chk("offset",   32'(bus.layer_offset_o),    32'(m_hoff));
    chk("stride",   32'(bus.layer_stride_o),    32'(m_hstr));
    chk("layer_no", 32'(bus.layer_no_o),        32'(m_hln));
`ifdef ACTMEM_SEQ_PERFCNT_EN
    chk("cycles",   bus.cycles_o,               m_cyc);
    chk("stalls",   bus.stall_cycles_o,         m_stall);
`endif
    if (bus.latch_new_layer_o) begin
      lat_offs.push_back(int'(bus.layer_offset_o));
      lat_cyc = cyc;
    end
    if (bus.done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.error_o) err_cnt++;
  endtask

  task automatic cycle(input bit r, input bit st, input bit ab, input bit vl,
                       input int np, input int px, input int ln);
    rst_i            = r;
    bus.start_i      = st;
    bus.abort_i      = ab;
    bus.valid_i      = vl;
    bus.num_passes_i = DECW'(np);
    bus.pixels_i     = PIXW'(px);
    bus.layer_no_i   = LNW'(ln);
    @(posedge clk_i);
    model_step(r, st, ab, vl, np, px, ln);
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0);
  endtask

  // vmode 0: valid every cycle, 1: valid every other cycle, 2: valid plus start noise
  task automatic run_until_done(input int budget, input int vmode, output bit seen);
    int base;
    bit v, s;
    base = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      v = (vmode == 1) ? k[0] : 1'b1;
      s = (vmode == 2);
      cycle(1'b0, s, 1'b0, v, 1, 2, 77);
      seen = (done_cnt != base);
    end
  endtask

  initial begin
    bit seen, r, st, ab, vl;
    int np, px, e0, d0;

    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.valid_i = 1'b0;
    bus.num_passes_i = '0; bus.pixels_i = '0; bus.layer_no_i = '0;
    m_busy = 0; m_latch = 0; m_done = 0; m_err = 0; m_pass = 0; m_passes = 0;
    m_pixels = 0; m_left = 0; m_hoff = 0; m_hstr = 0; m_hln = 0; m_cyc = 0; m_stall = 0;
    lat_cyc = 0; done_cyc = 0; done_cnt = 0; err_cnt = 0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_pass", 32'(bus.pass_o), 32'd0);
    idle(2);

    // single pass, continuous valid
    lat_offs.delete();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 128);
    run_until_done(30, 0, seen);
    chk("sp_done_seen", 32'(seen), 32'd1);
    chk("sp_latches", 32'(lat_offs.size()), 32'd1);
    chk("sp_lat_to_done", 32'(done_cyc - lat_cyc), 32'd5);
    idle(2);

    // two passes, valid every other cycle
    lat_offs.delete();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 3, 40);
    run_until_done(40, 1, seen);
    chk("tp_done_seen", 32'(seen), 32'd1);
    chk("tp_latches", 32'(lat_offs.size()), 32'd2);
    if (lat_offs.size() == 2) begin
      chk("tp_off0", 32'(lat_offs[0]), 32'd0);
      chk("tp_off1", 32'(lat_offs[1]), 32'd1);
    end
    idle(2);

    // illegal configurations: zero passes, zero pixels, too many passes
    for (int t = 0; t < 3; t++) begin
      np = (t == 0) ? 0 : ((t == 1) ? 1 : ITD + 1);
      px = (t == 1) ? 0 : 3;
      e0 = err_cnt;
      cycle(1'b0, 1'b1, 1'b0, 1'b0, np, px, 5);
      idle(1);
      chk("ill_err", 32'(err_cnt - e0), 32'd1);
      chk("ill_busy", 32'(bus.busy_o), 32'd0);
    end

    // abort after two of four valids, then a clean restart
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 9);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    d0 = done_cnt;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1, 4, 9);
    chk("ab_busy", 32'(bus.busy_o), 32'd0);
    idle(3);
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 10);
    run_until_done(30, 0, seen);
    chk("ab_restart_timing", 32'(done_cyc - lat_cyc), 32'd5);

    // spurious valid in IDLE, start during RUN and DONE
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 33);
    run_until_done(30, 2, seen);
    chk("spur_timing", 32'(done_cyc - lat_cyc), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 0);
    chk("spur_done_idle", 32'(bus.busy_o), 32'd0);
    idle(2);

    // reset mid-layer
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3, 5, 100);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_rst_stride", 32'(bus.layer_stride_o), 32'd0);
    idle(2);

`ifdef ACTMEM_SEQ_PERFCNT_EN
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    idle(3);
    chk("perf_stall", bus.stall_cycles_o, 32'd2);
    chk("perf_cycles", bus.cycles_o, 32'd6);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 79) == 0);
      vl = ($urandom_range(0, 2) != 0);
      np = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, ITD));
      px = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      cycle(r, st, ab, vl, np, px, int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
